mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 133 +++++++++++++
 tb/tb_mem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a req/gnt/rvalid handshake with programmable
// grant and response latency; one transaction in flight at a time.
module mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0010_0000,
    parameter int          GNT_DELAY = 1,
    parameter int          RSP_DELAY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        error_o
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

    typedef enum logic [2:0] {IDLE, WAIT_GNT, GRANT, WAIT_RSP, RESP} state_t;

    state_t         state, state_d;
    logic [2:0]     cnt, cnt_d;
    logic [31:0]    mem [DEPTH];
    logic [31:0]    offset;
    logic           in_range;
    logic [AW-1:0]  widx;
    logic [31:0]    acc_data, rsp_data;
    logic           acc_err, rsp_err;
    logic           unused_low;

    // Subtraction first so the range test never wraps past 2^32.
    assign offset     = addr_i - BASE_ADDR;
    assign in_range   = (addr_i >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign widx       = offset[AW+1:2];
    assign unused_low = ^offset[1:0];

    always_comb begin
        acc_data = '0;
        acc_err  = !in_range;
        if (in_range && !we_i)
            acc_data = mem[widx];
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (GNT_DELAY == 0) begin
                        state_d = GRANT;
                    end else begin
                        state_d = WAIT_GNT;
                        cnt_d   = 3'(GNT_DELAY);
                    end
                end
            end
            WAIT_GNT: begin
                // Withdrawn request wins over an expiring counter.
                if (!req_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt <= 3'd1) begin
                    state_d = GRANT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            GRANT: begin
                if (RSP_DELAY == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT_RSP;
                    cnt_d   = 3'(RSP_DELAY - 1);
                end
            end
            WAIT_RSP: begin
                if (cnt <= 3'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            gnt_o    <= 1'b0;
            rvalid_o <= 1'b0;
            error_o  <= 1'b0;
            rdata_o  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            gnt_o    <= (state_d == GRANT);
            rvalid_o <= (state_d == RESP);
            if (state == GRANT) begin
                rsp_data <= acc_data;
                rsp_err  <= acc_err;
            end
            // GRANT->RESP directly bypasses the holding registers.
            if (state_d == RESP) begin
                rdata_o <= (state == GRANT) ? acc_data : rsp_data;
                error_o <= (state == GRANT) ? acc_err  : rsp_err;
            end else begin
                error_o <= 1'b0;
            end
        end
    end

    // Store has no reset; only the GRANT cycle may write it.
    always_ff @(posedge clk) begin
        if (reset && state == GRANT && we_i && in_range) begin
            for (int k = 0; k < 4; k++)
                if (be_i[k])
                    mem[widx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: default-parameter instance for access/latency/reset cases,
// plus a GNT_DELAY=0/RSP_DELAY=1 instance for back-to-back streaming.
module tb_mem_responder;
    localparam int GD = 1;
    localparam int RD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rv, err;
    logic [31:0] rdata;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = 32'h0010_0000, wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic        gnt2, rv2, err2;
    logic [31:0] rdata2;

    int checks = 0, errors = 0;
    int viol1 = 0, viol2 = 0, r2cnt = 0;
    logic out1 = 1'b0, out2 = 1'b0, g2_prev = 1'b0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .reset(reset), .req_i(req), .addr_i(addr), .wdata_i(wdata),
        .we_i(we), .be_i(be), .gnt_o(gnt), .rvalid_o(rv), .rdata_o(rdata), .error_o(err)
    );

    mem_responder #(.GNT_DELAY(0), .RSP_DELAY(1)) dut2 (
        .clk(clk), .reset(reset), .req_i(req2), .addr_i(addr2), .wdata_i(wdata2),
        .we_i(we2), .be_i(be2), .gnt_o(gnt2), .rvalid_o(rv2), .rdata_o(rdata2), .error_o(err2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // Protocol monitors: error only with rvalid, never a second grant in flight,
    // and on dut2 every rvalid directly follows its grant.
    always @(negedge clk) begin
        if (!reset) begin
            out1 <= 1'b0;
            out2 <= 1'b0;
            g2_prev <= 1'b0;
        end else begin
            viol1 <= viol1 + int'((err && !rv) || (gnt && out1));
            out1  <= gnt ? 1'b1 : (rv ? 1'b0 : out1);
            viol2 <= viol2 + int'((rv2 && !g2_prev) || (gnt2 && out2) || (err2 && !rv2));
            out2  <= gnt2 ? 1'b1 : (rv2 ? 1'b0 : out2);
            r2cnt <= r2cnt + int'(rv2);
            g2_prev <= gnt2;
        end
    end

    task automatic txn(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er);
        int k;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        k = 0;
        while (!gnt && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_gnt_lat"}, k, GD + 1);
        // Scramble inputs after the grant cycle; the in-flight response must not move.
        @(posedge clk); #1;
        req = 1'b0; we = 1'b1; addr = 32'h0010_0000; wdata = 32'hFFFF_FFFF; be = 4'hF;
        k = 1;
        while (!rv && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk({tag, "_rsp_lat"}, k, RD);
        rd = rdata;
        er = err;
        @(posedge clk); #1;
        we = 1'b0;
        chk({tag, "_hold"}, rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          k, n;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {28'd0, gnt, rv, err, 1'b0}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk) reset = 1'b1;

        txn("wr_full", 1'b1, 32'h0010_0010, 32'hDEAD_BEEF, 4'b1111, rd, er);
        chk("wr_full_rdata", rd, 32'd0);
        chk("wr_full_err", {31'd0, er}, 32'd0);
        txn("rd1", 1'b0, 32'h0010_0010, 32'h0, 4'b0000, rd, er);
        chk("rd1_data", rd, 32'hDEAD_BEEF);
        chk("rd1_err", {31'd0, er}, 32'd0);

        txn("wr_be", 1'b1, 32'h0010_0012, 32'h1122_3344, 4'b0101, rd, er);
        txn("rd2", 1'b0, 32'h0010_0010, 32'h0, 4'b0000, rd, er);
        chk("rd2_data", rd, 32'hDE22_BE44);

        txn("oor_lo", 1'b0, 32'h000F_FFFC, 32'h0, 4'b0000, rd, er);
        chk("oor_lo_data", rd, 32'd0);
        chk("oor_lo_err", {31'd0, er}, 32'd1);
        txn("oor_hi", 1'b0, 32'h0010_1000, 32'h0, 4'b0000, rd, er);
        chk("oor_hi_data", rd, 32'd0);
        chk("oor_hi_err", {31'd0, er}, 32'd1);
        txn("rd3", 1'b0, 32'h0010_0010, 32'h0, 4'b0000, rd, er);
        chk("rd3_data", rd, 32'hDE22_BE44);

        // Edges of the window, be=0 no-op, out-of-range write that would alias word 0.
        txn("wr_w0", 1'b1, 32'h0010_0000, 32'h0BAD_F00D, 4'b1111, rd, er);
        txn("wr_top", 1'b1, 32'h0010_0FFC, 32'hA5A5_5A5A, 4'b1111, rd, er);
        chk("wr_top_err", {31'd0, er}, 32'd0);
        txn("wr_be0", 1'b1, 32'h0010_0000, 32'hFFFF_FFFF, 4'b0000, rd, er);
        txn("wr_oor", 1'b1, 32'h0010_1000, 32'h1234_5678, 4'b1111, rd, er);
        chk("wr_oor_err", {31'd0, er}, 32'd1);
        txn("rd_w0", 1'b0, 32'h0010_0003, 32'h0, 4'b0000, rd, er);
        chk("rd_w0_data", rd, 32'h0BAD_F00D);
        txn("rd_top", 1'b0, 32'h0010_0FFC, 32'h0, 4'b0000, rd, er);
        chk("rd_top_data", rd, 32'hA5A5_5A5A);
        chk("rd_top_err", {31'd0, er}, 32'd0);

        // Request withdrawn while waiting for grant.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0010_0010;
        @(posedge clk); #1;
        chk("drop_wait_gnt", {31'd0, gnt}, 32'd0);
        @(negedge clk) req = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | gnt | rv;
        end
        chk("drop_none", {31'd0, seen}, 32'd0);
        txn("after_drop", 1'b0, 32'h0010_0010, 32'h0, 4'b0000, rd, er);
        chk("after_drop_data", rd, 32'hDE22_BE44);

        // Reset pulse while a read waits for its response.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h0010_0FFC;
        k = 0;
        while (!gnt && k < 20) begin
            @(posedge clk); #1; k++;
        end
        chk("abort_gnt_lat", k, GD + 1);
        @(posedge clk); #1;
        req = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_outs", {28'd0, gnt, rv, err, 1'b0}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            seen = seen | rv;
        end
        chk("abort_no_rv", {31'd0, seen}, 32'd0);
        txn("after_abort", 1'b0, 32'h0010_0010, 32'h0, 4'b0000, rd, er);
        chk("after_abort_data", rd, 32'hDE22_BE44);

        // Streaming on the zero-grant-delay instance with req held high.
        @(negedge clk) req2 = 1'b1;
        k = 0;
        n = 0;
        while (n < 4 && k < 40) begin
            @(posedge clk); #1; k++;
            if (gnt2) n++;
        end
        req2 = 1'b0;
        chk("d2_gnts", n, 4);
        chk("d2_span", k, 10);
        repeat (4) @(posedge clk);
        #1;
        chk("d2_rvalids", r2cnt, 4);
        chk("d2_protocol", viol2, 0);
        chk("d1_protocol", viol1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
